snd_i2s_tx: RTL and testbench
=============================

SND_I2S_TX -- requirements
Module: snd_i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 4, ACLK cycles per BCLK half-period; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer entries; power of two.
REQ-003 ACLK  in  1  block clock; all logic on rising edge.
REQ-004 ARST  in  1  reset; synchronous, active-high.
REQ-005 en  in  1  transmitter enable.
REQ-006 din  in  16  signed PCM sample from the FIR filter output.
REQ-007 din_valid  in  1  one-cycle strobe qualifying din; there is no back-pressure.
REQ-008 stat_clr  in  1  clears the sticky status flags.
REQ-009 BCLK  out  1  serial bit clock.
REQ-010 LRCK  out  1  word select; 0 = left, 1 = right.
REQ-011 SDATA  out  1  serial data, MSB first, I2S format.
REQ-012 fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
REQ-013 ovf  out  1  sticky: a sample was dropped because the FIFO was full.
REQ-014 udf  out  1  sticky: a frame started with the FIFO empty.

Function
REQ-015 Divider: div_cnt counts 0..BCLK_DIV-1 while en=1; at terminal count BCLK toggles and div_cnt wraps to 0.
REQ-016 A BCLK 1->0 transition is a falling event; slot counter (5 bits, 0..31) increments modulo 32 on each falling event.
REQ-017 LRCK is 0 for slots 0..15 and 1 for slots 16..31; it is updated in the same cycle as the slot change.
REQ-018 On the falling event entering slot 1: pop the FIFO head into hold_reg and load it into the 16-bit shift register.
REQ-019 On the falling event entering slot 17: load hold_reg into the shift register, so the mono sample is sent on both channels.
REQ-020 On every other falling event the shift register shifts left by one and fills with 0; SDATA = shift_reg[15], registered.
REQ-021 Resulting placement (one-bit I2S delay): left MSB in slot 1, left LSB in slot 16; right MSB in slot 17, right LSB in slot 0 of the next frame.
REQ-022 Empty at the slot-1 pop: hold_reg = 0, udf set, no pop occurs.
REQ-023 Push occurs when din_valid=1 and the FIFO is not full; when full, din is dropped and ovf is set.
REQ-024 Push and pop in the same cycle while full: both occur, level unchanged, ovf not set.
REQ-025 Push and pop in the same cycle while empty: the pop sees empty (udf set), the push is stored, level becomes 1.
REQ-026 FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH; fifo_level reflects the registered occupancy.
REQ-027 stat_clr=1 clears ovf and udf next cycle; a set event in the same cycle as stat_clr takes priority, leaving the flag at 1.
REQ-028 en=0: next cycle BCLK=0, LRCK=0, SDATA=0, div_cnt=0, slot=0, shift_reg=0, FIFO flushed (level 0), and din_valid is ignored.
REQ-029 en 0->1: the first BCLK rise occurs BCLK_DIV cycles later and the first falling event (entering slot 1) occurs 2*BCLK_DIV cycles later.
REQ-030 din is treated as raw 16 bits; no rescaling or saturation.

Reset
REQ-031 ARST=1 forces BCLK=0, LRCK=0, SDATA=0, fifo_level=0, ovf=0, udf=0, div_cnt=0, slot=0, and clears hold_reg and shift_reg.
REQ-032 ARST has priority over en, din_valid and stat_clr, including mid-frame; there is no partial-frame completion.

Verification (BCLK_DIV=4)
REQ-033 Reset, en=1, push 16'hA5C3 -> BCLK period 8 ACLK; slots 1..16 carry 1010010111000011 on SDATA with LRCK=0; slots 17..31 and next slot 0 carry it again with LRCK=1.
REQ-034 en=1 with no samples -> SDATA stays 0 for a whole frame, udf=1 after the first slot-1 event; stat_clr -> udf=0.
REQ-035 Push 6 samples back-to-back before the first pop (FIFO_DEPTH=4) -> fifo_level=4, ovf=1, samples 5 and 6 are lost, and samples 1..4 are emitted in order over 4 frames.
REQ-036 din_valid asserted in the slot-1 pop cycle with the FIFO full -> level stays 4 and ovf stays 0.
REQ-037 Deassert en mid-slot 9, then reassert -> outputs go 0 next cycle, level=0, and the first BCLK rise occurs 4 cycles after reassertion.
REQ-038 ARST pulsed mid-frame with 3 samples queued -> all outputs and flags 0, and the queued samples are never transmitted.

Source files
------------

// File: rtl/snd_i2s_tx.sv
// ---------------------------------------------------------------------------
// snd_i2s_tx -- mono-to-stereo I2S transmitter with a small sample FIFO.
//
// The FIR filter output is strobed in (din/din_valid), queued in a FIFO and
// sent once per frame. The same sample goes out on the left and right
// channels, MSB first, with the standard one-bit I2S delay after LRCK.
// The bit clock is derived from ACLK: each BCLK half-period lasts BCLK_DIV
// ACLK cycles.
//
// Parameters
//   BCLK_DIV    ACLK cycles per BCLK half-period (2..255)
//   FIFO_DEPTH  sample buffer entries (power of two, >= 2)
//
// Ports
//   ACLK        block clock, all logic on the rising edge
//   ARST        synchronous active-high reset
//   en          transmitter enable; low flushes the FIFO and idles the bus
//   din         16-bit signed PCM sample (sent as raw bits)
//   din_valid   one-cycle strobe qualifying din (no back-pressure)
//   stat_clr    clears the sticky ovf/udf flags
//   BCLK        serial bit clock
//   LRCK        word select (0 = left, 1 = right)
//   SDATA       serial data
//   fifo_level  current FIFO occupancy
//   ovf         sticky: a sample was dropped because the FIFO was full
//   udf         sticky: a frame started with the FIFO empty
// ---------------------------------------------------------------------------
module snd_i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         ACLK,
    input  logic                         ARST,
    input  logic                         en,
    input  logic [15:0]                  din,
    input  logic                         din_valid,
    input  logic                         stat_clr,
    output logic                         BCLK,
    output logic                         LRCK,
    output logic                         SDATA,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         ovf,
    output logic                         udf
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [4:0]       r_slot;
    logic             r_lrck;
    logic [15:0]      r_shift;
    logic [15:0]      r_hold;
    logic             r_sdata;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_ovf;
    logic             r_udf;
    logic [15:0]      r_fifo_mem [FIFO_DEPTH];

    // ---------------------------------------------------------------------
    // Combinational decode
    // ---------------------------------------------------------------------
    logic             w_tc;
    logic             w_fall;
    logic             w_empty;
    logic             w_full;
    logic             w_pop_slot;
    logic             w_reload;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [15:0]      w_head;
    logic [15:0]      w_hold_next;
    logic [15:0]      w_shift_next;
    logic [4:0]       w_slot_next;

    assign w_tc        = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    // A falling event is the terminal count while BCLK is currently high.
    assign w_fall      = en && w_tc && r_bclk;
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_slot_next = r_slot + 5'd1;

    // Leaving slot 0 starts a frame (fetch a new sample); leaving slot 16
    // starts the right channel (replay the held sample).
    assign w_pop_slot  = w_fall && (r_slot == 5'd0);
    assign w_reload    = w_fall && (r_slot == 5'd16);

    assign w_pop       = w_pop_slot && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign w_push      = en && din_valid && (!w_full || w_pop);
    assign w_ovf_set   = en && din_valid && w_full && !w_pop;
    assign w_udf_set   = w_pop_slot && w_empty;

    // The head is read asynchronously; hold_reg is the register stage that
    // captures it, so the sample is available on the pop edge itself.
    assign w_head      = r_fifo_mem[r_rd_ptr];

    always_comb begin
        w_hold_next = r_hold;
        if (w_pop_slot) begin
            // An empty FIFO at frame start sends silence on both channels.
            w_hold_next = w_pop ? w_head : 16'h0000;
        end
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_pop_slot) begin
            w_shift_next = w_hold_next;
        end else if (w_reload) begin
            w_shift_next = r_hold;
        end else if (w_fall) begin
            w_shift_next = {r_shift[14:0], 1'b0};
        end
    end

    // ---------------------------------------------------------------------
    // Bit clock, slot counter and serialiser
    // ---------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_slot    <= 5'd0;
            r_lrck    <= 1'b0;
            r_shift   <= 16'h0000;
            r_hold    <= 16'h0000;
            r_sdata   <= 1'b0;
        end else if (!en) begin
            // Idle: everything restarts from a clean frame boundary. hold_reg
            // is left alone; it is always refilled before it is sent again.
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_slot    <= 5'd0;
            r_lrck    <= 1'b0;
            r_shift   <= 16'h0000;
            r_sdata   <= 1'b0;
        end else begin
            if (w_tc) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_slot <= w_slot_next;
                r_lrck <= w_slot_next[4];
            end
            r_hold  <= w_hold_next;
            r_shift <= w_shift_next;
            // SDATA tracks the MSB of the shifter as it will be after this
            // edge, so data changes on the same edge as the slot.
            r_sdata <= w_shift_next[15];
        end
    end

    // ---------------------------------------------------------------------
    // Sample FIFO
    // ---------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST || !en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Sticky status; a new event wins over a simultaneous clear.
    // ---------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (stat_clr ? 1'b0 : r_ovf) | w_ovf_set;
            r_udf <= (stat_clr ? 1'b0 : r_udf) | w_udf_set;
        end
    end

    assign BCLK       = r_bclk;
    assign LRCK       = r_lrck;
    assign SDATA      = r_sdata;
    assign fifo_level = r_level;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

endmodule

// File: tb/tb_snd_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_snd_i2s_tx -- self-checking bench for snd_i2s_tx (BCLK_DIV=4, depth 4).
//
// A frame-level model (enabled-cycle count, sample queue, current sample)
// predicts BCLK/LRCK/SDATA/fifo_level/ovf/udf every cycle; directed
// scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_snd_i2s_tx;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 64 * D;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        en;
    logic [15:0] din;
    logic        din_valid;
    logic        stat_clr;
    logic        BCLK;
    logic        LRCK;
    logic        SDATA;
    logic [2:0]  fifo_level;
    logic        ovf;
    logic        udf;

    snd_i2s_tx #(.BCLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .stat_clr   (stat_clr),
        .BCLK       (BCLK),
        .LRCK       (LRCK),
        .SDATA      (SDATA),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          m_k = 0;          // enabled cycles since idle/reset
    logic [15:0] m_q[$];
    logic [15:0] m_cur = 16'h0000; // sample of the current frame
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    task automatic model_step();
        bit ovf_evt;
        bit udf_evt;
        bit pop_slot;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        if (ARST) begin
            m_k = 0;
            m_q.delete();
            m_cur = 16'h0000;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        if (!en) begin
            m_k = 0;
            m_q.delete();
        end else begin
            m_k++;
            // Falling events happen every 2*D enabled cycles; the one that
            // lands on slot 1 starts a frame.
            pop_slot = (m_k % (2 * D) == 0) && ((m_k / (2 * D)) % 32 == 1);
            if (pop_slot) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                end else begin
                    m_cur   = 16'h0000;
                    udf_evt = 1'b1;
                end
            end
            if (din_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(din);
                else ovf_evt = 1'b1;
            end
        end
        m_ovf = (stat_clr ? 1'b0 : m_ovf) | ovf_evt;
        m_udf = (stat_clr ? 1'b0 : m_udf) | udf_evt;
    endtask

    function automatic logic exp_sdata();
        int f;
        int s;
        f = m_k / (2 * D);
        s = f % 32;
        if (s >= 1 && s <= 16) return m_cur[16 - s];
        if (s >= 17)           return m_cur[32 - s];
        return (f > 0) ? m_cur[0] : 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge ACLK);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge ACLK);
            if (chk_on) begin
                check("cyc_bclk",  BCLK,  ((m_k / D) % 2));
                check("cyc_lrck",  LRCK,  (((m_k / (2 * D)) % 32) >= 16));
                check("cyc_sdata", SDATA, exp_sdata());
                check("cyc_level", fifo_level, m_q.size());
                check("cyc_ovf",   ovf,   m_ovf);
                check("cyc_udf",   udf,   m_udf);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [15:0] pat;
        logic [3:0]  nib;
        int          ones;

        ARST = 1'b1; en = 1'b0; din = 16'h0000; din_valid = 1'b0; stat_clr = 1'b0;
        cyc(3);
        chk_on = 1'b1;
        check("rst_bclk",  BCLK, 0);
        check("rst_lrck",  LRCK, 0);
        check("rst_sdata", SDATA, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf",   ovf, 0);
        check("rst_udf",   udf, 0);
        ARST = 1'b0;
        cyc(1);

        // One sample, sent on both channels.
        en = 1'b1; din_valid = 1'b1; din = 16'hA5C3;
        cyc(1);                                     // k=1
        din_valid = 1'b0;
        check("t1_level", fifo_level, 1);
        cyc(2);                                     // k=3
        check("t1_bclk_low", BCLK, 0);
        cyc(1);                                     // k=4
        check("t1_bclk_rise", BCLK, 1);
        cyc(8);                                     // k=12, mid slot 1
        pat = 16'hA5C3;
        for (int s = 1; s <= 32; s++) begin
            check($sformatf("t1_sdata_s%0d", s), SDATA, pat[15 - ((s - 1) % 16)]);
            check($sformatf("t1_lrck_s%0d", s), LRCK, ((s % 32) >= 16));
            cyc(8);
        end                                         // k=268
        check("t2_udf_set", udf, 1);
        stat_clr = 1'b1;
        cyc(1);                                     // k=269
        stat_clr = 1'b0;
        check("t2_udf_clr", udf, 0);
        cyc(250);                                   // k=519
        stat_clr = 1'b1;                            // clear coincides with empty pop
        cyc(1);                                     // k=520
        stat_clr = 1'b0;
        check("t2_udf_prio", udf, 1);
        check("t2_ovf", ovf, 0);

        // Overflow: six pushes into a depth-4 FIFO.
        en = 1'b0;
        cyc(1);
        en = 1'b1; din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 16'(4369 * (i + 1));
            cyc(1);
        end                                         // k=6
        din_valid = 1'b0;
        check("t3_level_full", fifo_level, 4);
        check("t3_ovf_set", ovf, 1);
        cyc(6);                                     // k=12
        for (int j = 0; j < 4; j++) begin
            nib = 4'h0;
            for (int s = 0; s < 4; s++) begin
                nib = {nib[2:0], SDATA};
                cyc(8);
            end
            check($sformatf("t3_frame%0d_nibble", j), nib, j + 1);
            cyc(FRAME - 32);
        end                                         // k=1036
        check("t3_ovf_sticky", ovf, 1);
        stat_clr = 1'b1;
        cyc(1);
        stat_clr = 1'b0;
        check("t3_ovf_clr", ovf, 0);
        check("t3_udf_clr", udf, 0);

        // Push into a full FIFO on the pop cycle.
        en = 1'b0;
        cyc(1);
        en = 1'b1; din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 16'hC000 + 16'(i);
            cyc(1);
        end                                         // k=4
        din_valid = 1'b0;
        cyc(3);                                     // k=7
        din_valid = 1'b1; din = 16'h7777;
        cyc(1);                                     // k=8, pop + push
        din_valid = 1'b0;
        check("t4_level", fifo_level, 4);
        check("t4_ovf", ovf, 0);

        // Drop enable mid slot 9, then restart.
        cyc(69);                                    // k=77
        check("t5_bclk_before", BCLK, 1);
        en = 1'b0; din_valid = 1'b1; din = 16'hFFFF;
        cyc(1);
        din_valid = 1'b0;
        check("t5_bclk_off",  BCLK, 0);
        check("t5_lrck_off",  LRCK, 0);
        check("t5_sdata_off", SDATA, 0);
        check("t5_level_off", fifo_level, 0);
        cyc(1);
        check("t5_level_ign", fifo_level, 0);
        en = 1'b1;
        cyc(3);
        check("t5_bclk_low", BCLK, 0);
        cyc(1);                                     // k=4
        check("t5_bclk_rise", BCLK, 1);

        // Reset mid-frame with three samples queued.
        cyc(10);                                    // k=14
        din_valid = 1'b1;
        din = 16'hFFFF; cyc(1);
        din = 16'hFFFE; cyc(1);
        din = 16'hFFFD; cyc(1);                     // k=17
        din_valid = 1'b0;
        check("t6_level_q", fifo_level, 3);
        cyc(80);                                    // k=97
        ARST = 1'b1;
        cyc(2);
        check("t6_bclk",  BCLK, 0);
        check("t6_lrck",  LRCK, 0);
        check("t6_sdata", SDATA, 0);
        check("t6_level", fifo_level, 0);
        check("t6_ovf",   ovf, 0);
        check("t6_udf",   udf, 0);
        ARST = 1'b0;
        ones = 0;
        repeat (300) begin
            cyc(1);
            ones += int'(SDATA);
        end
        check("t6_no_tx", ones, 0);
        check("t6_udf_after", udf, 1);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
